// File: rtl/char_damage_pkg.sv
// Shared game-level types and constants for the character health logic.
package game_pkg;

  localparam logic [1:0] GAME_PLAY = 2'd1;
  localparam int         HP_W      = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALIVE  = 2'd1,
    INVULN = 2'd2,
    DEAD   = 2'd3
  } dmg_state_t;

endpackage : game_pkg

// File: rtl/char_damage_if.sv
// Bundle of frame, geometry, projectile and health signals around char_damage.
interface char_damage_if;
  import game_pkg::*;

  logic            frame_tick;
  logic [1:0]      game_active;
  logic            game_start;
  logic [11:0]     char_x;
  logic [11:0]     char_y;
  logic [11:0]     char_lng;
  logic [11:0]     char_hgt;
  logic [11:0]     boss_x;
  logic [11:0]     boss_y;
  logic [11:0]     boss_lng;
  logic [11:0]     boss_hgt;
  logic            proj_hit;
  logic [3:0]      proj_dmg;
  logic [HP_W-1:0] char_hp;
  logic            char_dead;
  logic            invuln;
  logic            hit_pulse;

  modport master (
    output frame_tick, game_active, game_start,
    output char_x, char_y, char_lng, char_hgt,
    output boss_x, boss_y, boss_lng, boss_hgt,
    output proj_hit, proj_dmg,
    input  char_hp, char_dead, invuln, hit_pulse
  );

  modport slave (
    input  frame_tick, game_active, game_start,
    input  char_x, char_y, char_lng, char_hgt,
    input  boss_x, boss_y, boss_lng, boss_hgt,
    input  proj_hit, proj_dmg,
    output char_hp, char_dead, invuln, hit_pulse
  );

endinterface : char_damage_if

// File: rtl/char_damage_aabb.sv
// Combinational axis-aligned rectangle intersection; touching edges do not overlap.
module aabb_overlap (
  input  logic [11:0] ax_i,
  input  logic [11:0] ay_i,
  input  logic [11:0] aw_i,
  input  logic [11:0] ah_i,
  input  logic [11:0] bx_i,
  input  logic [11:0] by_i,
  input  logic [11:0] bw_i,
  input  logic [11:0] bh_i,
  output logic        overlap_o
);

  // 13-bit far edges so a box near the screen limit cannot wrap to a small value
  logic [12:0] a_right, a_bottom, b_right, b_bottom;
  logic        nonzero;

  assign a_right  = {1'b0, ax_i} + {1'b0, aw_i};
  assign a_bottom = {1'b0, ay_i} + {1'b0, ah_i};
  assign b_right  = {1'b0, bx_i} + {1'b0, bw_i};
  assign b_bottom = {1'b0, by_i} + {1'b0, bh_i};

  // A degenerate box can still satisfy the strict inequalities, so reject it explicitly
  assign nonzero = (aw_i != '0) && (ah_i != '0) && (bw_i != '0) && (bh_i != '0);

  assign overlap_o = nonzero
                  && ({1'b0, ax_i} < b_right)
                  && ({1'b0, bx_i} < a_right)
                  && ({1'b0, ay_i} < b_bottom)
                  && ({1'b0, by_i} < a_bottom);

endmodule : aabb_overlap

// File: rtl/char_damage.sv
// Character health FSM: contact and projectile damage, post-hit invulnerability, death hold.
module char_damage
  import game_pkg::*;
#(
  parameter logic [HP_W-1:0] MAX_HP      = 4'd8,
  parameter logic [3:0]      CONTACT_DMG = 4'd1,
  parameter logic [7:0]      IFRAMES     = 8'd60
) (
  input  logic          clk,
  input  logic          rst,
  char_damage_if.slave  bus
);

  dmg_state_t      state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [4:0]      pend_q, pend_d;
  logic            overlap_q, overlap_d;
  logic            hit_q, hit_d;
  logic            invuln_q, dead_q;

  logic [4:0] pend_sum, pend_acc, dmg;

  aabb_overlap u_overlap (
    .ax_i      (bus.char_x),
    .ay_i      (bus.char_y),
    .aw_i      (bus.char_lng),
    .ah_i      (bus.char_hgt),
    .bx_i      (bus.boss_x),
    .by_i      (bus.boss_y),
    .bw_i      (bus.boss_lng),
    .bh_i      (bus.boss_hgt),
    .overlap_o (overlap_d)
  );

  // Pending damage including a hit arriving this cycle, saturated at 15
  always_comb begin
    pend_sum = pend_q + {1'b0, bus.proj_dmg};
    pend_acc = pend_q;
    if (bus.proj_hit) begin
      pend_acc = (pend_sum > 5'd15) ? 5'd15 : pend_sum;
    end
    dmg = pend_acc + (overlap_q ? {1'b0, CONTACT_DMG} : 5'd0);
  end

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hit_d   = 1'b0;

    if (bus.game_start) begin
      state_d = ALIVE;
      hp_d    = MAX_HP;
      cnt_d   = '0;
      pend_d  = '0;
    end else if (bus.game_active != GAME_PLAY) begin
      state_d = IDLE;
      pend_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ALIVE: begin
          pend_d = pend_acc;
          if (bus.frame_tick && (dmg != 5'd0)) begin
            hit_d  = 1'b1;
            pend_d = '0;
            hp_d   = ({1'b0, hp_q} > dmg) ? (hp_q - dmg[HP_W-1:0]) : '0;
            if (hp_d == '0) begin
              state_d = DEAD;
            end else begin
              state_d = INVULN;
              cnt_d   = IFRAMES;
            end
          end
        end
        INVULN: begin
          // A count of 0 or 1 ends the window on this tick
          if (bus.frame_tick) begin
            if (cnt_q <= 8'd1) begin
              state_d = ALIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        DEAD: hp_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      hp_q      <= MAX_HP;
      cnt_q     <= '0;
      pend_q    <= '0;
      overlap_q <= 1'b0;
      hit_q     <= 1'b0;
      invuln_q  <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      overlap_q <= overlap_d;
      hit_q     <= hit_d;
      invuln_q  <= (state_d == INVULN);
      dead_q    <= (state_d == DEAD);
    end
  end

  assign bus.char_hp   = hp_q;
  assign bus.char_dead = dead_q;
  assign bus.invuln    = invuln_q;
  assign bus.hit_pulse = hit_q;

endmodule : char_damage

// File: tb/tb_char_damage.sv
// Directed bench for char_damage: contact, projectiles, invulnerability, death, mode and reset.
module tb_char_damage;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   err_cnt = 0;
  int   chk_cnt = 0;
  int   hits;

  always #5 clk = ~clk;

  char_damage_if bus ();

  char_damage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %-14s got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %-14s %0d", tag, obs);
    end
  endtask

  // Inputs are driven and outputs sampled 1 ns after each rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic tick_n(input int n, output int hit_count);
    hit_count = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.hit_pulse) hit_count++;
    end
  endtask

  task automatic start();
    bus.game_start = 1'b1;
    step();
    bus.game_start = 1'b0;
  endtask

  task automatic set_boss(input int bx, input int by, input int bl, input int bh);
    bus.boss_x   = 12'(bx);
    bus.boss_y   = 12'(by);
    bus.boss_lng = 12'(bl);
    bus.boss_hgt = 12'(bh);
  endtask

  task automatic proj(input int d);
    bus.proj_hit = 1'b1;
    bus.proj_dmg = 4'(d);
    step();
    bus.proj_hit = 1'b0;
    bus.proj_dmg = 4'd0;
  endtask

  initial begin
    rst = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.game_active = 2'd0;
    bus.game_start  = 1'b0;
    bus.char_x      = 12'd100;
    bus.char_y      = 12'd100;
    bus.char_lng    = 12'd16;
    bus.char_hgt    = 12'd16;
    set_boss(300, 300, 40, 40);
    bus.proj_hit    = 1'b0;
    bus.proj_dmg    = 4'd0;

    step(); step();
    check("rst_hp", bus.char_hp, 8);
    check("rst_dead", bus.char_dead, 0);
    check("rst_invuln", bus.invuln, 0);
    check("rst_hit", bus.hit_pulse, 0);
    rst = 1'b1;
    bus.game_active = GAME_PLAY;
    step();

    // Contact hit, then 60 frames of invulnerability
    start();
    check("start_hp", bus.char_hp, 8);
    set_boss(110, 105, 40, 40);
    step();
    tick();
    check("contact_hp", bus.char_hp, 7);
    check("contact_hit", bus.hit_pulse, 1);
    check("contact_inv", bus.invuln, 1);
    tick_n(59, hits);
    check("iframe_hits", hits, 0);
    check("iframe_hp", bus.char_hp, 7);
    check("iframe_inv59", bus.invuln, 1);
    tick();
    check("iframe_end", bus.invuln, 0);
    check("iframe_end_hp", bus.char_hp, 7);
    tick();
    check("second_hp", bus.char_hp, 6);
    check("second_hit", bus.hit_pulse, 1);

    // Touching edges and zero-size boxes never overlap
    start();
    set_boss(116, 100, 16, 16);
    step();
    tick_n(10, hits);
    check("edge_hits", hits, 0);
    check("edge_hp", bus.char_hp, 8);
    set_boss(115, 100, 16, 16);
    step();
    tick();
    check("one_px_hp", bus.char_hp, 7);
    start();
    set_boss(105, 105, 0, 20);
    step();
    tick_n(3, hits);
    check("zero_w_hits", hits, 0);
    check("zero_w_hp", bus.char_hp, 8);

    // Projectile and contact on the same tick
    start();
    set_boss(110, 105, 40, 40);
    step();
    bus.proj_hit   = 1'b1;
    bus.proj_dmg   = 4'd3;
    bus.frame_tick = 1'b1;
    step();
    bus.proj_hit   = 1'b0;
    bus.proj_dmg   = 4'd0;
    bus.frame_tick = 1'b0;
    check("simul_hp", bus.char_hp, 4);
    check("simul_hit", bus.hit_pulse, 1);

    // Accumulated projectiles; hits during INVULN are dropped
    start();
    set_boss(300, 300, 40, 40);
    step();
    proj(2);
    proj(1);
    tick();
    check("accum_hp", bus.char_hp, 5);
    proj(5);
    tick_n(60, hits);
    check("inv_proj_inv", bus.invuln, 0);
    tick();
    check("inv_proj_hp", bus.char_hp, 5);
    check("inv_proj_hit", bus.hit_pulse, 0);

    // Saturating pending damage kills; death holds
    start();
    proj(15);
    proj(15);
    tick();
    check("kill_hp", bus.char_hp, 0);
    check("kill_dead", bus.char_dead, 1);
    check("kill_inv", bus.invuln, 0);
    set_boss(110, 105, 40, 40);
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!bus.char_dead || bus.char_hp != 4'd0) hits++;
    end
    check("dead_hold", hits, 0);

    start();
    check("restart_hp", bus.char_hp, 8);
    check("restart_dead", bus.char_dead, 0);

    // Leaving play mode while invulnerable
    tick();
    check("mode_pre_inv", bus.invuln, 1);
    bus.game_active = 2'd0;
    step();
    check("mode_inv", bus.invuln, 0);
    check("mode_hp", bus.char_hp, 7);
    tick_n(5, hits);
    check("mode_hits", hits, 0);
    bus.game_active = GAME_PLAY;
    tick_n(5, hits);
    check("idle_hits", hits, 0);
    check("idle_hp", bus.char_hp, 7);
    start();
    tick();
    check("replay_hp", bus.char_hp, 7);
    check("replay_inv", bus.invuln, 1);

    // Asynchronous reset in the middle of a cycle
    rst = 1'b0;
    #2;
    check("arst_hp", bus.char_hp, 8);
    check("arst_inv", bus.invuln, 0);
    check("arst_hit", bus.hit_pulse, 0);
    check("arst_dead", bus.char_dead, 0);
    step();
    rst = 1'b1;
    step();
    bus.proj_hit = 1'b1;
    bus.proj_dmg = 4'd4;
    tick_n(3, hits);
    bus.proj_hit = 1'b0;
    check("post_rst_hits", hits, 0);
    check("post_rst_hp", bus.char_hp, 8);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_char_damage
